uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Baud-rate scheduler and transmit sequencer for the UART Avalon slave.
//  Owns the programmable baud divider and paces one 8-bit frame at a time
//  onto txd_o, with start, data, optional parity and stop bits.
//  Sits between the register file (divisor, data, valid) and the serial pin.
// PARAMETERS
//  DIV_W      16  width of the baud divisor; bit period = div_i clk_i cycles
//  STOP_BITS  1   number of stop bits per frame; legal values are 1 and 2
// PORTS
//  clk_i        in   1      system clock; all logic is on posedge
//  reset        in   1      synchronous reset, active-high
//  div_i        in   DIV_W  baud divisor in clk_i cycles per bit; 0 is treated as 1
//  tx_data_i    in   8      byte to send
//  tx_valid_i   in   1      byte offered
//  tx_ready_o   out  1      ready to accept a byte; high only in IDLE
//  txd_o        out  1      serial output; idles high
//  busy_o       out  1      frame in progress (not IDLE)
//  baud_tick_o  out  1      one-cycle pulse on the last cycle of each bit period
//  parity_odd_i in   1      under UART_PARITY_EN only: 1 = odd parity, 0 = even
// BEHAVIOUR
//  - Reset, applied on the clk_i edge: state IDLE, txd_o=1, tx_ready_o=1,
//    busy_o=0, baud_tick_o=0, counters 0.
//  - Handshake: a byte is accepted when tx_valid_i && tx_ready_o are both high
//    on a posedge.
//    - On acceptance, tx_data_i and div_i are latched.
//    - A latched div of 0 is forced to 1.
//    - Next cycle: state START, txd_o=0, tx_ready_o=0.
//  - Latency: txd_o falls one cycle after the accepting edge.
//  - Baud counter:
//    - Cleared on acceptance.
//    - Counts 0..div-1, then wraps to 0.
//    - baud_tick_o=1 while count==div-1.
//    - State advances on the same edge as the tick.
//  - FSM: IDLE -> START -> DATA(x8, LSB first) -> [PARITY] -> STOP(xSTOP_BITS) -> IDLE.
//  - Each bit holds txd_o for exactly div cycles.
//  - A 3-bit bit index counts DATA bits; a 1-bit index counts STOP bits.
//  - Frame length F = (1+8+P+STOP_BITS)*div cycles, where P=1 when parity is
//    compiled in, else 0.
//  - tx_ready_o and busy_o are registered.
//    - tx_ready_o is low, and busy_o is high, for exactly F cycles per frame.
//  - Back-to-back frames:
//    - tx_ready_o is high in the first IDLE cycle.
//    - If tx_valid_i is held high, the next start bit follows with no gap
//      beyond that one IDLE cycle.
//  - Changes to div_i or tx_data_i during a frame have no effect until the
//    next acceptance.
//  - tx_valid_i while busy is ignored; the source holds it until it sees ready.
//  - Reset mid-frame:
//    - Frame is abandoned and state forced to IDLE.
//    - Next cycle txd_o=1 and tx_ready_o=1.
//  - Simultaneous reset and valid: reset wins; no byte is accepted.
//  - Widths:
//    - Baud counter is DIV_W bits.
//    - div_i = 2^DIV_W-1 is legal; the wrap compare must not overflow.
// CONFIGURATION
//  - UART_PARITY_EN defined:
//    - Port parity_odd_i exists and is latched at acceptance.
//    - PARITY state sends ^data (even) or ~^data (odd) for div cycles, between
//      DATA and STOP.
//  - UART_PARITY_EN undefined: no parity_odd_i port, no PARITY state, P=0.
// TESTING
//  1. div=4, no parity, 1 stop, send 0xA5:
//     txd_o = 0,1,0,1,0,0,1,0,1,1 (one bit each 4 cycles);
//     tx_ready_o low for 40 cycles.
//  2. div=0, send 0x00: bit period is 1 cycle; frame is 10 cycles;
//     baud_tick_o high on every cycle of the frame.
//  3. tx_valid_i held high, bytes 0x12 then 0x34, div=2:
//     second start bit begins 2 cycles after the first frame's last stop
//     cycle (1 IDLE cycle, then the start bit).
//  4. Assert reset for 1 cycle at cycle 15 of a div=3 frame:
//     txd_o=1 and tx_ready_o=1 on the next cycle; no further bits are sent.
//  5. Change div_i from 4 to 8 mid-frame: the current frame keeps 4-cycle bits;
//     the next frame uses 8-cycle bits.
//  6. UART_PARITY_EN, parity_odd_i=1, 0x07, div=2, STOP_BITS=2:
//     parity bit = 0; frame = 12 bits = 24 cycles.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between the UART register file and the transmit scheduler.
// The master offers tx_data_i/tx_valid_i; the slave answers with tx_ready_o.
interface uart_tx_sched_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;

  modport master (
    output tx_data_i,
    output tx_valid_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_valid_i,
    output tx_ready_o
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART baud scheduler and frame sequencer: start, 8 data bits LSB first, stop bit(s).
// Define UART_PARITY_EN to add the parity_odd_i port and a parity bit after the data.
module uart_tx_sched #(
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_i,
  uart_tx_sched_if.slave   tx_if,
`ifdef UART_PARITY_EN
  input  logic             parity_odd_i,
`endif
  output logic             txd_o,
  output logic             busy_o,
  output logic             baud_tick_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [DIV_W-1:0] ONE       = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ZERO      = '0;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             parity_bit;
  logic [DIV_W-1:0] last_cnt;
  logic             tick;
  logic             accept;

`ifdef UART_PARITY_EN
  logic parity_odd_q, parity_odd_d;
  assign parity_bit = (^data_d) ^ parity_odd_d;
`else
  assign parity_bit = 1'b0;
`endif

  // div_q is never 0, so div_q-1 cannot wrap and the compare holds at full width.
  assign last_cnt = div_q - ONE;
  assign tick     = (state_q != S_IDLE) && (cnt_q == last_cnt);
  assign accept   = (state_q == S_IDLE) && ready_q && tx_if.tx_valid_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
`ifdef UART_PARITY_EN
    parity_odd_d = parity_odd_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = tick ? ZERO : cnt_q + ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = ZERO;
          div_d   = (div_i == ZERO) ? ONE : div_i;
          data_d  = tx_if.tx_data_i;
`ifdef UART_PARITY_EN
          parity_odd_d = parity_odd_i;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin value and handshake flags are registered from the upcoming state.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[bit_idx_d];
      S_PARITY: txd_d = parity_bit;
      default:  txd_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= ZERO;
      div_q      <= ONE;
      data_q     <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_odd_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef UART_PARITY_EN
      parity_odd_q <= parity_odd_d;
`endif
    end
  end

  assign tx_if.tx_ready_o = ready_q;
  assign txd_o            = txd_q;
  assign busy_o           = busy_q;
  assign baud_tick_o      = tick;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: expected serial bits are queued at acceptance
// and popped while the frame is observed cycle by cycle.
module tb_uart_tx_sched;
  localparam int DIV_W = 4;
`ifdef UART_PARITY_EN
  localparam int TB_STOP = 2;
  localparam int P       = 1;
`else
  localparam int TB_STOP = 1;
  localparam int P       = 0;
`endif
  localparam int NBITS = 9 + P + TB_STOP;

  logic             clk_i = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] div_i;
  logic             parity_odd;
  logic             txd_o;
  logic             busy_o;
  logic             baud_tick_o;

  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];

  uart_tx_sched_if tx_if ();

  uart_tx_sched #(
    .DIV_W    (DIV_W),
    .STOP_BITS(TB_STOP)
  ) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .div_i       (div_i),
    .tx_if       (tx_if.slave),
`ifdef UART_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .txd_o       (txd_o),
    .busy_o      (busy_o),
    .baud_tick_o (baud_tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_PARITY_EN
    exp_q.push_back(parity_odd ? ~^d : ^d);
`endif
    for (int i = 0; i < TB_STOP; i++) exp_q.push_back(1'b1);
  endfunction

  // Waits (bounded) for ready at a negedge, lets the next posedge accept the byte.
  task automatic send(input logic [7:0] d, input int div, input bit hold);
    int n = 0;
    tx_if.tx_data_i  = d;
    div_i            = DIV_W'(div);
    tx_if.tx_valid_i = 1'b1;
    while (n < 200) begin
      @(negedge clk_i);
      if (tx_if.tx_ready_o === 1'b1) break;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 1, 0);
    @(posedge clk_i);
    #1;
    if (!hold) tx_if.tx_valid_i = 1'b0;
    push_frame(d);
    $display("send data=%02h div=%0d", d, div);
  endtask

  // Each bit must hold for d cycles with ready low, busy high and a tick on its last cycle.
  task automatic check_frame(input string name, input int div);
    int   d = (div == 0) ? 1 : div;
    int   bad_hs = 0;
    int   bad_tick = 0;
    int   bad_txd;
    logic exp_b;
    for (int b = 0; b < NBITS; b++) begin
      if (exp_q.size() == 0) begin
        chk({name, "_queue_empty"}, 1, 0);
        exp_b = 1'b1;
      end else begin
        exp_b = exp_q.pop_front();
      end
      bad_txd = 0;
      for (int c = 0; c < d; c++) begin
        @(negedge clk_i);
        if (txd_o !== exp_b) bad_txd++;
        if (tx_if.tx_ready_o !== 1'b0 || busy_o !== 1'b1) bad_hs++;
        if (baud_tick_o !== logic'(c == d - 1)) bad_tick++;
      end
      chk($sformatf("%s_bit%0d_bad_cycles", name, b), bad_txd, 0);
    end
    chk({name, "_handshake_bad_cycles"}, bad_hs, 0);
    chk({name, "_tick_bad_cycles"}, bad_tick, 0);
    @(negedge clk_i);
    chk({name, "_idle_ready"}, int'(tx_if.tx_ready_o), 1);
    chk({name, "_idle_busy"}, int'(busy_o), 0);
    chk({name, "_idle_txd"}, int'(txd_o), 1);
    $display("frame %s checked div=%0d errors=%0d", name, d, errors);
  endtask

  initial begin
    int bad;
    reset            = 1'b1;
    div_i            = '0;
    parity_odd       = 1'b0;
    tx_if.tx_data_i  = 8'h00;
    tx_if.tx_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_txd", int'(txd_o), 1);
    chk("reset_ready", int'(tx_if.tx_ready_o), 1);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_tick", int'(baud_tick_o), 0);
    reset = 1'b0;

    send(8'hA5, 4, 1'b0);
    check_frame("a5_div4", 4);

    send(8'h00, 0, 1'b0);
    check_frame("00_div0", 0);

    // Valid held: second start bit follows a single IDLE cycle.
    send(8'h12, 2, 1'b1);
    tx_if.tx_data_i = 8'h34;
    check_frame("12_b2b", 2);
    push_frame(8'h34);
    check_frame("34_b2b", 2);
    tx_if.tx_valid_i = 1'b0;

    // Inputs changed mid-frame must not disturb the latched byte and divisor.
    send(8'h3C, 4, 1'b0);
    div_i           = 4'd8;
    tx_if.tx_data_i = 8'hFF;
    check_frame("3c_div4_then8", 4);
    push_frame(8'h5A);
    tx_if.tx_data_i  = 8'h5A;
    tx_if.tx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    tx_if.tx_valid_i = 1'b0;
    check_frame("5a_div8", 8);

    send(8'h81, 15, 1'b0);
    check_frame("81_divmax", 15);

    // Reset at cycle 15 of a div=3 frame abandons it.
    send(8'hC3, 3, 1'b0);
    repeat (15) @(negedge clk_i);
    reset = 1'b1;
    @(posedge clk_i);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    chk("midreset_txd", int'(txd_o), 1);
    chk("midreset_ready", int'(tx_if.tx_ready_o), 1);
    chk("midreset_busy", int'(busy_o), 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (txd_o !== 1'b1 || tx_if.tx_ready_o !== 1'b1) bad++;
    end
    chk("midreset_quiet_cycles", bad, 0);
    $display("midreset checked errors=%0d", errors);

    // Reset and valid together: no byte is accepted.
    tx_if.tx_data_i  = 8'h55;
    tx_if.tx_valid_i = 1'b1;
    reset            = 1'b1;
    @(negedge clk_i);
    chk("rst_valid_busy", int'(busy_o), 0);
    chk("rst_valid_txd", int'(txd_o), 1);
    tx_if.tx_valid_i = 1'b0;
    reset            = 1'b0;
    @(negedge clk_i);
    chk("rst_valid_after_busy", int'(busy_o), 0);
    $display("reset_with_valid checked errors=%0d", errors);

`ifdef UART_PARITY_EN
    parity_odd = 1'b1;
    send(8'h07, 2, 1'b0);
    check_frame("07_odd_parity", 2);
    parity_odd = 1'b0;
    send(8'h07, 2, 1'b0);
    check_frame("07_even_parity", 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
